// File: rtl/mem_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl_if
// Purpose  : Data-memory request/ready port between the memory-access stage
//            (master) and the data memory (slave).
// Ports    : mem_req   - access request, held until mem_ready
//            mem_we    - 1 = write, 0 = read; meaningful with mem_req
//            mem_addr  - word address
//            mem_wdata - store data
//            mem_rdata - read data, valid with mem_ready
//            mem_ready - access complete
// Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl
// Purpose  : Memory-access stage of the 5-stage pipeline. Issues one data
//            memory access per load/store, freezes upstream stages while the
//            access is outstanding, aborts after TIMEOUT wait cycles with a
//            sticky error, and owns the MEM/WB pipeline register.
// Ports    : clk            - pipeline clock
//            rst            - asynchronous, active-low reset
//            WB_En_in, MEM_R_En_in, MEM_W_En_in, ALU_result_in, ST_val_in,
//            Instruction_in - EXE/MEM register outputs
//            mem            - data-memory request/ready port (master side)
//            freeze         - hold EXE/MEM and all earlier stages
//            mem_err        - sticky access-timeout flag
//            WB_En, MEM_R_En, ALU_result, Mem_read_value, Instruction
//                           - MEM/WB register outputs
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              WB_En_in,
    input  logic              MEM_R_En_in,
    input  logic              MEM_W_En_in,
    input  logic [31:0]       ALU_result_in,
    input  logic [31:0]       ST_val_in,
    input  logic [31:0]       Instruction_in,

    mem_stage_ctrl_if.master  mem,

    output logic              freeze,
    output logic              mem_err,

    output logic              WB_En,
    output logic              MEM_R_En,
    output logic [31:0]       ALU_result,
    output logic [31:0]       Mem_read_value,
    output logic [31:0]       Instruction
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [31:0]       r_rd_buf;
    logic              r_mem_err;

    logic              r_wb_en;
    logic              r_mem_r_en;
    logic [31:0]       r_alu_result;
    logic [31:0]       r_mem_read_value;
    logic [31:0]       r_instruction;

    logic              w_access;
    logic              w_busy;

    assign w_access = MEM_R_En_in | MEM_W_En_in;
    assign w_busy   = (r_state == S_BUSY);

    // Request and freeze are gated by rst so they drop the moment reset is
    // asserted, even in IDLE where freeze otherwise follows the inputs.
    assign mem.mem_req   = rst & w_busy;
    // A combined R=W instruction is issued as a write.
    assign mem.mem_we    = rst & w_busy & MEM_W_En_in;
    assign mem.mem_addr  = ALU_result_in[ADDR_W+1:2];
    assign mem.mem_wdata = ST_val_in;

    assign freeze = rst & (((r_state == S_IDLE) & w_access) | w_busy);

    assign mem_err        = r_mem_err;
    assign WB_En          = r_wb_en;
    assign MEM_R_En       = r_mem_r_en;
    assign ALU_result     = r_alu_result;
    assign Mem_read_value = r_mem_read_value;
    assign Instruction    = r_instruction;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_wait_cnt       <= '0;
            r_rd_buf         <= '0;
            r_mem_err        <= 1'b0;
            r_wb_en          <= 1'b0;
            r_mem_r_en       <= 1'b0;
            r_alu_result     <= '0;
            r_mem_read_value <= '0;
            r_instruction    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        // Hold the instruction here; write-back sees a bubble.
                        r_state          <= S_BUSY;
                        r_wait_cnt       <= '0;
                        r_wb_en          <= 1'b0;
                        r_mem_r_en       <= 1'b0;
                        r_alu_result     <= '0;
                        r_mem_read_value <= '0;
                        r_instruction    <= '0;
                    end else begin
                        r_wb_en          <= WB_En_in;
                        r_mem_r_en       <= MEM_R_En_in;
                        r_alu_result     <= ALU_result_in;
                        r_mem_read_value <= '0;
                        r_instruction    <= Instruction_in;
                    end
                end

                S_BUSY: begin
                    r_wb_en          <= 1'b0;
                    r_mem_r_en       <= 1'b0;
                    r_alu_result     <= '0;
                    r_mem_read_value <= '0;
                    r_instruction    <= '0;
                    // Ready on the final wait cycle still completes normally.
                    if (mem.mem_ready) begin
                        r_rd_buf <= MEM_W_En_in ? 32'd0 : mem.mem_rdata;
                        r_state  <= S_DONE;
                    end else if (r_wait_cnt == c_CNT_LAST) begin
                        r_mem_err <= 1'b1;
                        r_rd_buf  <= '0;
                        r_state   <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    // Upstream is released this cycle and advances on this edge.
                    r_wb_en          <= WB_En_in;
                    r_mem_r_en       <= MEM_R_En_in;
                    r_alu_result     <= ALU_result_in;
                    r_mem_read_value <= r_rd_buf;
                    r_instruction    <= Instruction_in;
                    r_state          <= S_IDLE;
                end

                default: begin
                    r_state          <= S_IDLE;
                    r_wb_en          <= 1'b0;
                    r_mem_r_en       <= 1'b0;
                    r_alu_result     <= '0;
                    r_mem_read_value <= '0;
                    r_instruction    <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Purpose  : Self-checking bench for mem_stage_ctrl: table vectors, reset and
//            timeout sequences, and randomized instructions against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        WB_En_in, MEM_R_En_in, MEM_W_En_in;
    logic [31:0] ALU_result_in, ST_val_in, Instruction_in;
    logic        freeze, mem_err, WB_En, MEM_R_En;
    logic [31:0] ALU_result, Mem_read_value, Instruction;

    mem_stage_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    mem_stage_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .WB_En_in       (WB_En_in),
        .MEM_R_En_in    (MEM_R_En_in),
        .MEM_W_En_in    (MEM_W_En_in),
        .ALU_result_in  (ALU_result_in),
        .ST_val_in      (ST_val_in),
        .Instruction_in (Instruction_in),
        .mem            (bus),
        .freeze         (freeze),
        .mem_err        (mem_err),
        .WB_En          (WB_En),
        .MEM_R_En       (MEM_R_En),
        .ALU_result     (ALU_result),
        .Mem_read_value (Mem_read_value),
        .Instruction    (Instruction)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    logic model_err = 1'b0;

    typedef struct {
        logic        wb, r, w;
        logic [31:0] alu, st, ins;
        int          k;          // BUSY cycle carrying ready; 0 = never
        logic [31:0] rd;
        int          fz;         // expected freeze cycles
        int          nreq;       // expected request cycles
        logic [31:0] rv;         // expected Mem_read_value
        bit          to;         // expected timeout
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: outcome of one instruction from the access rules.
    function automatic void model(input logic r, input logic w, input int k,
                                  input logic [31:0] rd, output int fz,
                                  output int nreq, output logic [31:0] rv,
                                  output bit to);
        if (!(r | w)) begin
            fz = 0; nreq = 0; rv = 32'd0; to = 1'b0;
        end else if (k >= 1 && k <= TIMEOUT) begin
            fz = 1 + k; nreq = k; rv = w ? 32'd0 : rd; to = 1'b0;
        end else begin
            fz = 1 + TIMEOUT; nreq = TIMEOUT; rv = 32'd0; to = 1'b1;
        end
    endfunction

    // Starts and ends at negedge+1. Presents one instruction, plays the
    // memory, and checks everything the instruction should produce.
    task automatic do_instr(input string tag, input vec_t v);
        int n_fz;
        int n_req;
        int cyc;
        bit done;
        bit bub_ok;
        bit port_ok;
        bit was_fz;
        logic [ADDR_W-1:0] exp_addr;
        n_fz = 0; n_req = 0; cyc = 0;
        done = 1'b0; bub_ok = 1'b1; port_ok = 1'b1;
        exp_addr = v.alu[ADDR_W+1:2];
        WB_En_in = v.wb; MEM_R_En_in = v.r; MEM_W_En_in = v.w;
        ALU_result_in = v.alu; ST_val_in = v.st; Instruction_in = v.ins;
        #1;
        while (!done && cyc < 64) begin
            was_fz = freeze;
            if (freeze) n_fz++;
            if (bus.mem_req) begin
                n_req++;
                if (bus.mem_we !== v.w || bus.mem_addr !== exp_addr || bus.mem_wdata !== v.st)
                    port_ok = 1'b0;
                bus.mem_ready = (n_req == v.k);
                bus.mem_rdata = v.rd;
            end else begin
                // Stray ready pulses outside an access must be ignored.
                bus.mem_ready = 1'($urandom_range(0, 1));
                bus.mem_rdata = $urandom;
            end
            @(negedge clk); #1;
            cyc++;
            if (was_fz) begin
                if (WB_En !== 1'b0 || MEM_R_En !== 1'b0 || ALU_result !== 32'd0 ||
                    Mem_read_value !== 32'd0 || Instruction !== 32'd0)
                    bub_ok = 1'b0;
            end else begin
                done = 1'b1;
            end
        end
        bus.mem_ready = 1'b0;
        model_err = model_err | v.to;
        check({tag, "/completed"}, 32'(done), 32'd1);
        check({tag, "/freeze_cycles"}, n_fz, v.fz);
        check({tag, "/req_cycles"}, n_req, v.nreq);
        check({tag, "/bubble"}, 32'(bub_ok), 32'd1);
        check({tag, "/port"}, 32'(port_ok), 32'd1);
        check({tag, "/WB_En"}, 32'(WB_En), 32'(v.wb));
        check({tag, "/MEM_R_En"}, 32'(MEM_R_En), 32'(v.r));
        check({tag, "/ALU_result"}, ALU_result, v.alu);
        check({tag, "/Instruction"}, Instruction, v.ins);
        check({tag, "/Mem_read_value"}, Mem_read_value, v.rv);
        check({tag, "/mem_err"}, 32'(mem_err), 32'(model_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        WB_En_in = 0; MEM_R_En_in = 0; MEM_W_En_in = 0;
        ALU_result_in = 0; ST_val_in = 0; Instruction_in = 0;
        bus.mem_ready = 0; bus.mem_rdata = 0;

        //               wb    r     w     alu           st            ins           k  rd            fz nreq rv            to
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,        32'h00A0_0093, 0, 32'h0,        0, 0, 32'h0,        1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0,        32'h0000_2083, 1, 32'hDEAD_BEEF, 2, 1, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0010_2023, 3, 32'h0,        4, 3, 32'h0,        1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'hABCD_1FFF, 32'h0,        32'h0000_3103, 4, 32'hCAFE_F00D, 5, 4, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0,        32'h0000_4183, 2, 32'h0BAD_C0DE, 3, 2, 32'h0BAD_C0DE, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0000_0108, 32'hA5A5_0F0F, 32'h0020_5023, 1, 32'hFFFF_FFFF, 2, 1, 32'h0,        1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h0000_0030, 32'h55AA_55AA, 32'h0030_6023, 2, 32'h7777_7777, 3, 2, 32'h0,        1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h8000_0001, 32'h0,        32'hFFFF_FFFF, 0, 32'h0,        0, 0, 32'h0,        1'b0};

        // Reset state, checked between edges.
        repeat (2) @(negedge clk);
        #2;
        check("reset/freeze", 32'(freeze), 32'd0);
        check("reset/mem_req", 32'(bus.mem_req), 32'd0);
        check("reset/mem_err", 32'(mem_err), 32'd0);
        check("reset/WB_En", 32'(WB_En), 32'd0);
        check("reset/ALU_result", ALU_result, 32'd0);
        check("reset/Mem_read_value", Mem_read_value, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Table vectors, back to back.
        for (int i = 0; i < 8; i++) do_instr($sformatf("vec%0d", i), vecs[i]);

        // Randomized instructions against the model.
        for (int i = 0; i < 40; i++) begin
            int kind;
            kind  = int'($urandom_range(0, 3));
            v.wb  = 1'($urandom);
            v.r   = (kind == 1 || kind == 3);
            v.w   = (kind == 2 || kind == 3);
            v.alu = $urandom; v.st = $urandom; v.ins = $urandom; v.rd = $urandom;
            v.k   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
            model(v.r, v.w, v.k, v.rd, v.fz, v.nreq, v.rv, v.to);
            do_instr($sformatf("rnd%0d", i), v);
        end

        // Timeout: ready never arrives; error is sticky afterwards.
        v = vecs[1];
        v.k = 0; v.rd = 32'h1357_9BDF;
        model(v.r, v.w, v.k, v.rd, v.fz, v.nreq, v.rv, v.to);
        do_instr("timeout", v);
        for (int i = 0; i < 10; i++) begin
            v = vecs[0];
            v.alu = $urandom | 32'h1;
            v.ins = $urandom;
            do_instr($sformatf("post_to%0d", i), v);
        end

        // Reset mid-access: request drops at once, then the load re-issues.
        WB_En_in = 1; MEM_R_En_in = 1; MEM_W_En_in = 0;
        ALU_result_in = 32'h0000_0010; ST_val_in = 0; Instruction_in = 32'h0000_2083;
        bus.mem_ready = 0;
        begin
            int n;
            n = 0;
            #1;
            while (!bus.mem_req && n < 8) begin
                @(negedge clk); #1;
                n++;
            end
            check("midrst/reached_busy", 32'(bus.mem_req), 32'd1);
        end
        #2;
        rst = 1'b0;
        #1;
        check("midrst/mem_req", 32'(bus.mem_req), 32'd0);
        check("midrst/freeze", 32'(freeze), 32'd0);
        check("midrst/mem_err", 32'(mem_err), 32'd0);
        check("midrst/ALU_result", ALU_result, 32'd0);
        model_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        do_instr("midrst/reissue", vecs[1]);
        do_instr("midrst/after", vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
